// File: rtl/scheduler_pkg.sv
// Shared types and widths for the accelerator selector: schedule-info word
// layout, selector FSM states and a small round-robin helper.
package scheduler_pkg;

    localparam int MAX_ACC_TYPES = 16;
    localparam int ACC_TYPE_BITS = $clog2(MAX_ACC_TYPES);
    localparam int MAX_ACCS      = 16;
    localparam int ACC_IDX_BITS  = $clog2(MAX_ACCS);
    localparam int ACC_ID_BITS   = $clog2(MAX_ACCS) + 1;
    localparam int DATA_BITS     = 48;
    localparam int RSVD_BITS     = DATA_BITS - 3 * ACC_ID_BITS;

    localparam logic [ACC_ID_BITS-1:0] ONE_ID = ACC_ID_BITS'(1);

    // One schedule-info record; the reserved upper bits are carried through untouched.
    typedef struct packed {
        logic [RSVD_BITS-1:0]   rsvd;
        logic [ACC_ID_BITS-1:0] next_off;
        logic [ACC_ID_BITS-1:0] num_inst;
        logic [ACC_ID_BITS-1:0] first_acc;
    } sched_info_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SCAN = 2'd2,
        RESP = 2'd3
    } sel_state_e;

    // Advance a round-robin offset, wrapping at the instance count.
    function automatic logic [ACC_ID_BITS-1:0] wrapInc(
        input logic [ACC_ID_BITS-1:0] k,
        input logic [ACC_ID_BITS-1:0] num
    );
        return ((k + ONE_ID) == num) ? '0 : (k + ONE_ID);
    endfunction

endpackage

// File: rtl/scheduler_acc_selector.sv
// Round-robin accelerator selector. Reads the per-type schedule-info record,
// scans that type's instances against acc_free, returns the chosen id, and on
// response acceptance claims the accelerator and writes next_off back.
// Host configuration writes share the memory write port and win over requests.
// Optional statistics counters: define SCHEDULER_ACC_SELECTOR_STATS_EN.
//
// Handshakes: a transfer happens in any cycle where valid and ready are both
// high; req_ready/cfg_wr_ready do not depend on rsp_ready, and rsp_valid with
// its payload stays stable until rsp_ready is seen.
module scheduler_acc_selector
    import scheduler_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ACC_TYPE_BITS-1:0] req_acc_type,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic                     rsp_found,
    output logic [ACC_ID_BITS-1:0]   rsp_acc_id,
    input  logic [MAX_ACCS-1:0]      acc_free,
    output logic                     acc_claim_en,
    output logic [ACC_ID_BITS-1:0]   acc_claim_id,
    input  logic                     cfg_wr_en,
    output logic                     cfg_wr_ready,
    input  logic [ACC_TYPE_BITS-1:0] cfg_wr_addr,
    input  logic [DATA_BITS-1:0]     cfg_wr_din,
    output logic                     sinfo_a_en,
    output logic [ACC_TYPE_BITS-1:0] sinfo_a_addr,
    output logic [DATA_BITS-1:0]     sinfo_a_din,
    output logic                     sinfo_b_en,
    output logic [ACC_TYPE_BITS-1:0] sinfo_b_addr,
    input  logic [DATA_BITS-1:0]     sinfo_b_dout,
    output logic [1:0]               dbg_state
`ifdef SCHEDULER_ACC_SELECTOR_STATS_EN
    ,
    output logic [31:0]              stat_req_cnt,
    output logic [31:0]              stat_miss_cnt,
    output logic [31:0]              stat_scan_cyc
`endif
);

    localparam logic [ACC_ID_BITS:0] ACC_LIMIT = (ACC_ID_BITS + 1)'(MAX_ACCS);

    sel_state_e               state;
    sel_state_e               nextState;
    sched_info_t              rec;
    sched_info_t              loadRec;
    sched_info_t              wbRec;
    logic [ACC_TYPE_BITS-1:0] reqType;
    logic [ACC_ID_BITS-1:0]   k;
    logic [ACC_ID_BITS-1:0]   scanIdx;
    logic                     rspFound;
    logic [ACC_ID_BITS-1:0]   rspId;
    logic [ACC_ID_BITS:0]     candidate;
    logic                     candFree;
    logic                     lastScan;
    logic                     reqAccept;

    assign loadRec   = sched_info_t'(sinfo_b_dout);
    assign candidate = {1'b0, rec.first_acc} + {1'b0, k};
    // Indices past the last accelerator never count as free.
    assign candFree  = (candidate < ACC_LIMIT) && acc_free[candidate[ACC_IDX_BITS-1:0]];
    assign lastScan  = ((scanIdx + ONE_ID) == rec.num_inst);
    assign reqAccept = (state == IDLE) && req_valid && !cfg_wr_en;
    assign dbg_state = state;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    // Record latch, round-robin offset and scan result.
    always_ff @(posedge clk) begin
        if (rst) begin
            rec      <= '0;
            reqType  <= '0;
            k        <= '0;
            scanIdx  <= '0;
            rspFound <= 1'b0;
            rspId    <= '0;
        end else begin
            case (state)
                IDLE: if (reqAccept) reqType <= req_acc_type;
                LOAD: begin
                    rec      <= loadRec;
                    // A stale offset beyond the instance count restarts at 0.
                    k        <= (loadRec.next_off >= loadRec.num_inst) ? '0 : loadRec.next_off;
                    scanIdx  <= '0;
                    rspFound <= 1'b0;
                    rspId    <= '0;
                end
                SCAN: begin
                    if (candFree) begin
                        rspFound <= 1'b1;
                        rspId    <= candidate[ACC_ID_BITS-1:0];
                    end else begin
                        k       <= wrapInc(k, rec.num_inst);
                        scanIdx <= scanIdx + ONE_ID;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next-state and output decode; claim/writeback are suppressed while rst is high.
    always_comb begin
        nextState    = state;
        req_ready    = 1'b0;
        cfg_wr_ready = 1'b0;
        rsp_valid    = 1'b0;
        rsp_found    = 1'b0;
        rsp_acc_id   = '0;
        acc_claim_en = 1'b0;
        acc_claim_id = '0;
        sinfo_a_en   = 1'b0;
        sinfo_a_addr = '0;
        sinfo_a_din  = '0;
        sinfo_b_en   = 1'b0;
        sinfo_b_addr = '0;
        wbRec          = rec;
        wbRec.next_off = wrapInc(k, rec.num_inst);
        case (state)
            IDLE: begin
                cfg_wr_ready = 1'b1;
                req_ready    = !cfg_wr_en;
                if (cfg_wr_en) begin
                    sinfo_a_en   = 1'b1;
                    sinfo_a_addr = cfg_wr_addr;
                    sinfo_a_din  = cfg_wr_din;
                end else if (req_valid) begin
                    sinfo_b_en   = 1'b1;
                    sinfo_b_addr = req_acc_type;
                    nextState    = LOAD;
                end
            end
            LOAD: nextState = (loadRec.num_inst == '0) ? RESP : SCAN;
            SCAN: if (candFree || lastScan) nextState = RESP;
            RESP: begin
                rsp_valid  = 1'b1;
                rsp_found  = rspFound;
                rsp_acc_id = rspId;
                if (rsp_ready) begin
                    nextState = IDLE;
                    if (rspFound && !rst) begin
                        acc_claim_en = 1'b1;
                        acc_claim_id = rspId;
                        sinfo_a_en   = 1'b1;
                        sinfo_a_addr = reqType;
                        sinfo_a_din  = wbRec;
                    end
                end
            end
            default: nextState = IDLE;
        endcase
    end

`ifdef SCHEDULER_ACC_SELECTOR_STATS_EN
    // Saturating request, miss and scan-cycle counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_req_cnt  <= '0;
            stat_miss_cnt <= '0;
            stat_scan_cyc <= '0;
        end else begin
            if (reqAccept && (stat_req_cnt != '1))
                stat_req_cnt <= stat_req_cnt + 32'd1;
            if ((state == RESP) && rsp_ready && !rspFound && (stat_miss_cnt != '1))
                stat_miss_cnt <= stat_miss_cnt + 32'd1;
            if ((state == SCAN) && (stat_scan_cyc != '1))
                stat_scan_cyc <= stat_scan_cyc + 32'd1;
        end
    end
`endif

endmodule
